banana_collision_tracker: RTL and testbench
===========================================

BANANA_COLLISION_TRACKER -- requirements
Module: banana_collision_tracker

Interface
REQ-001 The block SHALL take parameter RESPAWN_FRAMES, default 120, as the number of frames the banana stays hidden after a shot hit (legal range 1..1023).
REQ-002 The block SHALL have port clk, input, 1, system clock.
REQ-003 The block SHALL have port resetN, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port startOfFrame, input, 1, one-cycle pulse at the first pixel of each frame.
REQ-005 The block SHALL have port bananaDR, input, 1, banana bitmap drawingRequest for the current pixel.
REQ-006 The block SHALL have port bananaHitEdge, input, 4, banana bitmap HitEdgeCode for the current pixel (bit3 left, bit2 top, bit1 right, bit0 bottom).
REQ-007 The block SHALL have port playerDR, input, 1, player drawingRequest for the current pixel.
REQ-008 The block SHALL have port shotDR, input, 1, shot drawingRequest for the current pixel.
REQ-009 The block SHALL have port appear, output, 1, banana visibility, fed back to the bitmap appear input.
REQ-010 The block SHALL have port collisionPulse, output, 1, one-cycle pulse on the first collision pixel of a frame.
REQ-011 The block SHALL have port scoreEvent, output, 1, one-cycle pulse on the first shot collision of a frame.
REQ-012 The block SHALL have port hitEdgeLatched, output, 4, OR of all banana edge codes that collided during the previous frame.
REQ-013 The block SHALL have port hitCount, output, 8, number of shot hits, saturating.

Function
REQ-014 Collision pixel: bananaDR && appear && (playerDR || shotDR); a shot pixel is additionally a shot collision if shotDR=1.
REQ-015 collisionPulse SHALL assert for exactly one cycle, registered, on the cycle after the first collision pixel of a frame; later collision pixels in that frame SHALL NOT pulse.
REQ-016 scoreEvent SHALL follow the same rule independently, for shot collisions only; a player-only collision SHALL NOT raise scoreEvent.
REQ-017 Each collision pixel SHALL OR bananaHitEdge into an internal accumulator.
REQ-018 On startOfFrame, hitEdgeLatched SHALL load the accumulator, and the accumulator and the per-frame pulse flags SHALL clear.
REQ-019 A collision pixel coincident with startOfFrame SHALL belong to the new frame: the accumulator SHALL take its code after the clear, and that collision SHALL be eligible to pulse.
REQ-020 The FSM SHALL have states VISIBLE (appear=1), HIT_PENDING (appear=1), and HIDDEN (appear=0).
REQ-021 VISIBLE SHALL go to HIT_PENDING on a shot collision; HIT_PENDING SHALL go to HIDDEN on the next startOfFrame, and the frame counter SHALL load 0 at that point.
REQ-022 In HIT_PENDING, further shot collisions SHALL NOT re-trigger scoreEvent in a later frame.
REQ-023 HIDDEN SHALL increment the 10-bit frame counter on each startOfFrame; when the counter reaches RESPAWN_FRAMES on a startOfFrame, the FSM SHALL go to VISIBLE in that cycle.
REQ-024 hitCount SHALL increment by 1 on each scoreEvent and SHALL saturate at 255.
REQ-025 Player-only collisions SHALL NOT change the FSM state.

Reset
REQ-026 On resetN=0, asynchronously: state=VISIBLE, appear=1, collisionPulse=0, scoreEvent=0, hitEdgeLatched=0, hitCount=0, accumulator=0, frame counter=0, flags clear.
REQ-027 A reset asserted while in HIDDEN or HIT_PENDING SHALL return the block to VISIBLE immediately, with no pending score.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef, the edge-bit index constants (EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0), and the hit counter width.
REQ-029 The block SHALL contain one sub-module, frame_delay_counter, which counts startOfFrame pulses up to a load value and flags done.

Verification
REQ-030 Player overlap test: VISIBLE, 3 player-collision pixels in one frame with codes 4'h8, 4'h8, 4'h1 -> one collisionPulse, scoreEvent=0, hitEdgeLatched=4'h9 after the next startOfFrame, appear stays 1.
REQ-031 Shot hit test: one shot collision with code 4'h2 -> collisionPulse and scoreEvent one cycle later, hitCount=1, appear=1 until the next startOfFrame, then 0.
REQ-032 Respawn timing test: with RESPAWN_FRAMES=3 after a shot hit -> appear=0 for exactly 3 frames and returns to 1 on the 3rd startOfFrame after entering HIDDEN; a collision pixel while hidden (appear=0) gives no pulse.
REQ-033 Frame boundary test: a collision pixel on the same cycle as startOfFrame, code 4'h4 -> accumulator holds 4'h4 for the new frame, the previous frame's latch is unaffected, and collisionPulse fires.
REQ-034 Saturation test: 260 shot hits, with a respawn between each -> hitCount=255.
REQ-035 Reset-in-HIDDEN test: resetN pulsed low during HIDDEN -> appear=1, hitCount=0, and all outputs are at reset values asynchronously.

Source files
------------

// File: rtl/banana_collision_tracker_pkg.sv
// banana_collision_tracker_pkg: shared FSM state type, edge-bit indices and counter widths
package banana_collision_tracker_pkg;
  typedef enum logic [1:0] {VISIBLE, HIT_PENDING, HIDDEN} state_t;
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;
  localparam int HIT_CNT_W   = 8;
  localparam int FRAME_CNT_W = 10;
endpackage

// File: rtl/banana_collision_tracker_frame_delay_counter.sv
// frame_delay_counter: counts frame ticks from zero, flags the tick that reaches i_target
// Ports: clk, resetN (async active-low), i_clear (restart at 0), i_tick (count one frame),
//        i_target (count to reach), o_done (combinational, high on the reaching tick)
module frame_delay_counter
  import banana_collision_tracker_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   i_clear,
  input  logic                   i_tick,
  input  logic [FRAME_CNT_W-1:0] i_target,
  output logic                   o_done
);
  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [FRAME_CNT_W:0]   w_inc;
  assign w_inc  = {1'b0, r_cnt} + 1'b1;
  assign o_done = i_tick && (w_inc == {1'b0, i_target});
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_tick) r_cnt <= w_inc[FRAME_CNT_W-1:0];
endmodule

// File: rtl/banana_collision_tracker.sv
// banana_collision_tracker: banana collision detection, per-frame pulses, hide/respawn FSM, hit score
// Ports: clk, resetN (async active-low), startOfFrame, bananaDR, bananaHitEdge[3:0], playerDR,
//        shotDR in; appear, collisionPulse, scoreEvent, hitEdgeLatched[3:0], hitCount[7:0] out
module banana_collision_tracker
  import banana_collision_tracker_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 bananaDR,
  input  logic [3:0]           bananaHitEdge,
  input  logic                 playerDR,
  input  logic                 shotDR,
  output logic                 appear,
  output logic                 collisionPulse,
  output logic                 scoreEvent,
  output logic [3:0]           hitEdgeLatched,
  output logic [HIT_CNT_W-1:0] hitCount
);
  state_t     r_state, w_next;
  logic       w_col, w_shot, w_score, w_done;
  logic       r_col_seen, r_shot_seen;
  logic [3:0] r_acc, w_edge;
  assign appear = r_state != HIDDEN;
  assign w_col  = bananaDR && appear && (playerDR || shotDR);
  assign w_shot = w_col && shotDR;
  assign w_edge = {bananaHitEdge[EDGE_LEFT], bananaHitEdge[EDGE_TOP],
                   bananaHitEdge[EDGE_RIGHT], bananaHitEdge[EDGE_BOTTOM]};
  // Only a fresh hit while fully visible scores; HIT_PENDING swallows further shots.
  assign w_score = w_shot && (r_state == VISIBLE) && (startOfFrame || !r_shot_seen);
  frame_delay_counter u_delay (
    .clk      (clk),
    .resetN   (resetN),
    .i_clear  (r_state == HIT_PENDING && startOfFrame),
    .i_tick   (r_state == HIDDEN && startOfFrame),
    .i_target (FRAME_CNT_W'(RESPAWN_FRAMES)),
    .o_done   (w_done)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      VISIBLE:     w_next = w_shot ? HIT_PENDING : VISIBLE;
      HIT_PENDING: w_next = startOfFrame ? HIDDEN : HIT_PENDING;
      HIDDEN:      w_next = w_done ? VISIBLE : HIDDEN;
      default:     w_next = VISIBLE;
    endcase
  end
  // A collision on the startOfFrame cycle belongs to the new frame, so the
  // per-frame flags and accumulator are cleared and re-seeded in the same cycle.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state        <= VISIBLE;
      collisionPulse <= 1'b0;
      scoreEvent     <= 1'b0;
      r_col_seen     <= 1'b0;
      r_shot_seen    <= 1'b0;
      r_acc          <= '0;
      hitEdgeLatched <= '0;
      hitCount       <= '0;
    end else begin
      r_state        <= w_next;
      collisionPulse <= w_col && (startOfFrame || !r_col_seen);
      scoreEvent     <= w_score;
      r_col_seen     <= (!startOfFrame && r_col_seen) || w_col;
      r_shot_seen    <= (!startOfFrame && r_shot_seen) || w_shot;
      r_acc          <= (startOfFrame ? 4'h0 : r_acc) | (w_col ? w_edge : 4'h0);
      if (startOfFrame) hitEdgeLatched <= r_acc;
      if (w_score && hitCount != '1) hitCount <= hitCount + 1'b1;
    end
endmodule

// File: tb/tb_banana_collision_tracker.sv
// tb_banana_collision_tracker: directed and randomized checks against a frame-level reference model
module tb_banana_collision_tracker;
  localparam int RESPAWN = 3;
  logic       clk = 0, resetN = 0, sof = 0, bdr = 0, pdr = 0, sdr = 0;
  logic [3:0] edg = 0;
  logic       appear, collisionPulse, scoreEvent;
  logic [3:0] hitEdgeLatched;
  logic [7:0] hitCount;
  int n_checks = 0, n_fail = 0;
  bit         m_hidden, m_pending, m_col_seen, e_pulse, e_score;
  int         m_left, e_hits;
  logic [3:0] m_acc, e_latch;

  banana_collision_tracker #(.RESPAWN_FRAMES(RESPAWN)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .bananaDR(bdr), .bananaHitEdge(edg),
    .playerDR(pdr), .shotDR(sdr), .appear(appear), .collisionPulse(collisionPulse),
    .scoreEvent(scoreEvent), .hitEdgeLatched(hitEdgeLatched), .hitCount(hitCount));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hidden = 0; m_pending = 0; m_col_seen = 0; m_left = 0; m_acc = 0;
    e_pulse = 0; e_score = 0; e_hits = 0; e_latch = 0;
  endtask

  // Drives one pixel cycle, advances the reference model, samples 1ns after the edge.
  task automatic step(input bit s, input bit b, input logic [3:0] e, input bit p, input bit sh);
    bit col, shot;
    sof = s; bdr = b; edg = e; pdr = p; sdr = sh;
    col  = b && !m_hidden && (p || sh);
    shot = col && sh;
    e_pulse = col && (s || !m_col_seen);
    e_score = shot && !m_pending;
    if (e_score && e_hits < 255) e_hits++;
    if (s) e_latch = m_acc;
    m_acc = (s ? 4'h0 : m_acc) | (col ? e : 4'h0);
    m_col_seen = (!s && m_col_seen) || col;
    if (s && m_pending) begin m_pending = 0; m_hidden = 1; m_left = RESPAWN; end
    else if (s && m_hidden) begin m_left--; if (m_left == 0) m_hidden = 0; end
    else if (shot && !m_pending) m_pending = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks += 5;
    if (appear !== 1'b1) begin n_fail++; $display("FAIL reset_appear got %b want 1", appear); end
    if (collisionPulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", collisionPulse); end
    if (scoreEvent !== 1'b0) begin n_fail++; $display("FAIL reset_score got %b want 0", scoreEvent); end
    if (hitEdgeLatched !== 4'h0) begin n_fail++; $display("FAIL reset_latch got %h want 0", hitEdgeLatched); end
    if (hitCount !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", hitCount); end
  endtask

  task automatic test_player_overlap();
    int pulses = 0, scores = 0;
    step(1, 0, 0, 0, 0);
    step(0, 1, 4'h8, 1, 0); pulses += collisionPulse; scores += scoreEvent;
    step(0, 0, 0, 0, 0);    pulses += collisionPulse; scores += scoreEvent;
    step(0, 1, 4'h8, 1, 0); pulses += collisionPulse; scores += scoreEvent;
    step(0, 1, 4'h1, 1, 0); pulses += collisionPulse; scores += scoreEvent;
    step(0, 0, 0, 0, 0);    pulses += collisionPulse; scores += scoreEvent;
    step(1, 0, 0, 0, 0);
    n_checks += 4;
    if (pulses != 1) begin n_fail++; $display("FAIL player_pulses got %0d want 1", pulses); end
    if (scores != 0) begin n_fail++; $display("FAIL player_scores got %0d want 0", scores); end
    if (hitEdgeLatched !== 4'h9) begin n_fail++; $display("FAIL player_latch got %h want 9", hitEdgeLatched); end
    if (appear !== 1'b1) begin n_fail++; $display("FAIL player_appear got %b want 1", appear); end
  endtask

  task automatic test_shot_hit();
    step(0, 1, 4'h2, 0, 1);
    n_checks += 4;
    if (collisionPulse !== 1'b1) begin n_fail++; $display("FAIL shot_pulse got %b want 1", collisionPulse); end
    if (scoreEvent !== 1'b1) begin n_fail++; $display("FAIL shot_score got %b want 1", scoreEvent); end
    if (hitCount !== 8'd1) begin n_fail++; $display("FAIL shot_count got %0d want 1", hitCount); end
    if (appear !== 1'b1) begin n_fail++; $display("FAIL shot_appear got %b want 1", appear); end
    step(0, 1, 4'h2, 0, 1);
    n_checks += 2;
    if (scoreEvent !== 1'b0) begin n_fail++; $display("FAIL shot_rescore got %b want 0", scoreEvent); end
    if (appear !== 1'b1) begin n_fail++; $display("FAIL shot_pending_appear got %b want 1", appear); end
    step(1, 0, 0, 0, 0);
    n_checks += 1;
    if (appear !== 1'b0) begin n_fail++; $display("FAIL shot_hidden_appear got %b want 0", appear); end
  endtask

  task automatic test_respawn();
    step(0, 1, 4'hf, 1, 1);
    n_checks += 1;
    if (collisionPulse !== 1'b0) begin n_fail++; $display("FAIL hidden_pulse got %b want 0", collisionPulse); end
    for (int k = 1; k <= RESPAWN; k++) begin
      step(1, 0, 0, 0, 0);
      n_checks += 1;
      if (appear !== (k == RESPAWN)) begin n_fail++; $display("FAIL respawn_sof%0d got %b want %b", k, appear, k == RESPAWN); end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_frame_boundary();
    step(0, 1, 4'h1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 4'h4, 1, 0);
    n_checks += 2;
    if (collisionPulse !== 1'b1) begin n_fail++; $display("FAIL boundary_pulse got %b want 1", collisionPulse); end
    if (hitEdgeLatched !== 4'h1) begin n_fail++; $display("FAIL boundary_prev_latch got %h want 1", hitEdgeLatched); end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks += 1;
    if (hitEdgeLatched !== 4'h4) begin n_fail++; $display("FAIL boundary_new_latch got %h want 4", hitEdgeLatched); end
  endtask

  task automatic test_random();
    int gap = 0;
    for (int i = 0; i < 1500; i++) begin
      step(gap == 0, $urandom_range(1, 0) == 1, 4'($urandom_range(15, 0)),
           $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 2);
      gap = (gap == 0) ? $urandom_range(10, 3) : gap - 1;
      n_checks += 5;
      if (appear !== !m_hidden) begin n_fail++; $display("FAIL rand_appear cyc %0d got %b want %b", i, appear, !m_hidden); end
      if (collisionPulse !== e_pulse) begin n_fail++; $display("FAIL rand_pulse cyc %0d got %b want %b", i, collisionPulse, e_pulse); end
      if (scoreEvent !== e_score) begin n_fail++; $display("FAIL rand_score cyc %0d got %b want %b", i, scoreEvent, e_score); end
      if (hitEdgeLatched !== e_latch) begin n_fail++; $display("FAIL rand_latch cyc %0d got %h want %h", i, hitEdgeLatched, e_latch); end
      if (hitCount !== 8'(e_hits)) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, hitCount, e_hits); end
    end
  endtask

  task automatic test_reset_hidden();
    step(1, 0, 0, 0, 0);
    if (m_hidden) for (int k = 0; k < RESPAWN; k++) step(1, 0, 0, 0, 0);
    step(0, 1, 4'h8, 1, 1);
    step(1, 1, 4'h2, 1, 0);
    n_checks += 1;
    if (appear !== 1'b0) begin n_fail++; $display("FAIL rsthid_pre_appear got %b want 0", appear); end
    #2 resetN = 0;
    #1;
    n_checks += 5;
    if (appear !== 1'b1) begin n_fail++; $display("FAIL rsthid_appear got %b want 1", appear); end
    if (hitCount !== 8'd0) begin n_fail++; $display("FAIL rsthid_count got %0d want 0", hitCount); end
    if (collisionPulse !== 1'b0) begin n_fail++; $display("FAIL rsthid_pulse got %b want 0", collisionPulse); end
    if (scoreEvent !== 1'b0) begin n_fail++; $display("FAIL rsthid_score got %b want 0", scoreEvent); end
    if (hitEdgeLatched !== 4'h0) begin n_fail++; $display("FAIL rsthid_latch got %h want 0", hitEdgeLatched); end
    @(posedge clk); #1;
    sof = 0; bdr = 0; pdr = 0; sdr = 0; edg = 0;
    resetN = 1;
    model_reset();
  endtask

  task automatic test_saturation();
    int missed = 0;
    for (int h = 0; h < 260; h++) begin
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'h2, 0, 1);
      if (scoreEvent !== 1'b1) missed++;
      for (int k = 0; k <= RESPAWN; k++) begin
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
      end
    end
    n_checks += 3;
    if (missed != 0) begin n_fail++; $display("FAIL sat_scores missed %0d want 0", missed); end
    if (hitCount !== 8'd255) begin n_fail++; $display("FAIL sat_count got %0d want 255", hitCount); end
    if (hitCount !== 8'(e_hits)) begin n_fail++; $display("FAIL sat_model got %0d want %0d", hitCount, e_hits); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    resetN = 1;
    test_player_overlap();
    test_shot_hit();
    test_respawn();
    test_frame_boundary();
    test_random();
    test_reset_hidden();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
